// File: rtl/keypad_scan_buffer.sv
// Scans an active-low keypad matrix one column at a time, debounces a single
// key per press, and queues its code (row*N_COLS + col) in a small FIFO.
module keypad_scan_buffer #(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int SCAN_DIV   = 4,
  parameter int DEB_CYCLES = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(N_ROWS * N_COLS),
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [N_ROWS-1:0] filas_raw,
  output logic [N_COLS-1:0] columnas,
  output logic [CW-1:0]     key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [N_COLS-1:0] key_pressed,
  output logic [AW:0]       fifo_count,
  output logic              overflow
);

  localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CLW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int BW  = $clog2(DEB_CYCLES);

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    PUSH,
    HOLD,
    RELEASE
  } state_t;

  state_t          state;
  logic [N_ROWS-1:0] sync1;
  logic [N_ROWS-1:0] rows;
  logic [CLW-1:0]  col_idx;
  logic [CLW-1:0]  next_col;
  logic [RW-1:0]   row_idx;
  logic [RW-1:0]   low_row;
  logic            any_low;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   deb_cnt;

  logic [CW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   push_code;
  logic            full;
  logic            push;
  logic            pop;

  function automatic logic [N_COLS-1:0] col_drive(input logic [CLW-1:0] c);
    logic [N_COLS-1:0] v;
    v    = '1;
    v[c] = 1'b0;
    return v;
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= '1;
      rows  <= '1;
    end else begin
      sync1 <= filas_raw;
      rows  <= sync1;
    end
  end

  // Descending scan so the lowest-index low row is the one that sticks.
  always_comb begin
    low_row = '0;
    for (int unsigned i = N_ROWS; i > 0; i--) begin
      if (!rows[i-1]) low_row = RW'(i - 1);
    end
  end

  assign any_low  = !(&rows);
  assign next_col = (col_idx == CLW'(N_COLS - 1)) ? '0 : col_idx + 1'b1;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= SCAN;
      col_idx     <= '0;
      row_idx     <= '0;
      div_cnt     <= '0;
      deb_cnt     <= '0;
      columnas    <= {{(N_COLS-1){1'b1}}, 1'b0};
      key_pressed <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (div_cnt == DW'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            if (any_low) begin
              row_idx <= low_row;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_idx  <= next_col;
              columnas <= col_drive(next_col);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rows[row_idx]) begin
            state    <= SCAN;
            div_cnt  <= '0;
            col_idx  <= next_col;
            columnas <= col_drive(next_col);
          end else if (deb_cnt == BW'(DEB_CYCLES - 1)) begin
            state <= PUSH;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PUSH: begin
          key_pressed[col_idx] <= 1'b1;
          deb_cnt              <= '0;
          state                <= HOLD;
        end
        HOLD: begin
          if (rows[row_idx]) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!rows[row_idx]) begin
            deb_cnt <= '0;
            state   <= HOLD;
          end else if (deb_cnt == BW'(DEB_CYCLES - 1)) begin
            key_pressed <= '0;
            state       <= SCAN;
            div_cnt     <= '0;
            col_idx     <= next_col;
            columnas    <= col_drive(next_col);
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign push_code = CW'((int'(row_idx) * N_COLS) + int'(col_idx));
  assign full      = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign key_valid = (fifo_count != '0);
  assign key_code  = mem[rd_ptr];
  assign pop       = key_valid && key_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push      = (state == PUSH) && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
      if ((state == PUSH) && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_buffer.sv
// Directed bench for keypad_scan_buffer: a behavioural 4x4 keypad matrix
// drives the rows from the DUT column drive; expectations are hand-computed.
module tb_keypad_scan_buffer;

  localparam int NR = 4;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [3:0]  filas_raw;
  logic [3:0]  columnas;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic [3:0]  key_pressed;
  logic [2:0]  fifo_count;
  logic        overflow;

  logic [15:0] keys = '0;
  logic [3:0]  force_low = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
    logic [2:0] count;
    logic       ovf;
  } vec_t;

  vec_t tbl [5];

  keypad_scan_buffer #(
    .N_ROWS(4),
    .N_COLS(4),
    .SCAN_DIV(4),
    .DEB_CYCLES(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .filas_raw(filas_raw),
    .columnas(columnas),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_pressed(key_pressed),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // A held key shorts its row to its column, so the row reads low only while that column is driven.
  always_comb begin
    filas_raw = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (keys[r*NC+c] && !columnas[c]) filas_raw[r] = 1'b0;
    filas_raw = filas_raw & ~force_low;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col0(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (columnas != 4'b1110) break;
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (columnas == 4'b1110) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " col0 anchor"}, ok, 1);
  endtask

  task automatic wait_released(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (key_pressed == 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " release"}, ok, 1);
  endtask

  task automatic press_key(input int r, input int c, input bit release_it, input string name);
    bit ok;
    ok = 1'b0;
    keys[r*NC+c] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (key_pressed != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, " detect"}, ok, 1);
    check({name, " key_pressed"}, key_pressed, 32'd1 << c);
    check({name, " valid after push"}, key_valid, 1);
    repeat (5) tick();
    if (release_it) begin
      keys = '0;
      wait_released(name);
    end
  endtask

  task automatic do_reset();
    keys      = '0;
    force_low = '0;
    key_ready = 1'b0;
    n_reset   = 1'b0;
    repeat (2) tick();
    n_reset   = 1'b1;
  endtask

  initial begin
    tbl[0] = '{0, 0, 4'd0,  3'd1, 1'b0};
    tbl[1] = '{1, 2, 4'd6,  3'd2, 1'b0};
    tbl[2] = '{3, 3, 4'd15, 3'd3, 1'b0};
    tbl[3] = '{2, 0, 4'd8,  3'd4, 1'b0};
    tbl[4] = '{0, 3, 4'd3,  3'd4, 1'b1};

    repeat (3) tick();
    check("rst columnas", columnas, 4'b1110);
    check("rst key_valid", key_valid, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst key_pressed", key_pressed, 0);
    check("rst overflow", overflow, 0);

    n_reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("startup col0 edge%0d", i), columnas, 4'b1110);
    end
    repeat (2) tick();
    check("startup col1", columnas, 4'b1101);

    // Idle scanning
    wait_col0("idle");
    for (int i = 0; i < 64; i++) begin
      logic [3:0] exp_cols;
      if (i > 0) tick();
      exp_cols = 4'b1111;
      exp_cols[(i/4)%4] = 1'b0;
      check($sformatf("idle columnas %0d", i), columnas, exp_cols);
      check($sformatf("idle key_valid %0d", i), key_valid, 0);
    end

    // Single press row 2 col 1
    press_key(2, 1, 1'b0, "k9");
    check("k9 count", fifo_count, 1);
    check("k9 code", key_code, 9);
    check("k9 held key_pressed", key_pressed, 4'b0010);
    keys = '0;
    wait_released("k9");
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("k9 popped valid", key_valid, 0);
    check("k9 popped count", fifo_count, 0);

    // 3-cycle bounce on row 0 while column 0 is driven
    wait_col0("bounce");
    force_low = 4'b0001;
    repeat (3) tick();
    force_low = 4'b0000;
    repeat (2) tick();
    check("bounce frozen col0", columnas, 4'b1110);
    tick();
    check("bounce resume col1", columnas, 4'b1101);
    repeat (20) tick();
    check("bounce fifo_count", fifo_count, 0);
    check("bounce key_valid", key_valid, 0);
    check("bounce key_pressed", key_pressed, 0);

    // Five presses, no consumer: last one overflows
    for (int i = 0; i < 5; i++) begin
      press_key(tbl[i].row, tbl[i].col, 1'b1, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d count", i), fifo_count, tbl[i].count);
      check($sformatf("tbl%0d overflow", i), overflow, tbl[i].ovf);
      check($sformatf("tbl%0d head", i), key_code, tbl[0].code);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d valid", i), key_valid, 1);
      check($sformatf("drain%0d code", i), key_code, tbl[i].code);
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
    end
    check("drain empty", key_valid, 0);
    check("drain count", fifo_count, 0);
    check("overflow sticky", overflow, 1);

    // Full FIFO with a pop in the PUSH cycle
    do_reset();
    check("reset clears overflow", overflow, 0);
    for (int i = 0; i < 4; i++)
      press_key(tbl[i].row, tbl[i].col, 1'b1, $sformatf("fill%0d", i));
    check("fill count", fifo_count, 4);
    wait_col0("fullpop");
    keys[1*NC+0] = 1'b1;
    repeat (12) tick();
    check("fullpop pre-push pressed", key_pressed, 0);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("fullpop pushed", key_pressed, 4'b0001);
    check("fullpop count", fifo_count, 4);
    check("fullpop overflow", overflow, 0);
    check("fullpop head", key_code, tbl[1].code);
    keys = '0;
    wait_released("fullpop");
    begin
      logic [3:0] exp_q [4];
      exp_q[0] = tbl[1].code;
      exp_q[1] = tbl[2].code;
      exp_q[2] = tbl[3].code;
      exp_q[3] = 4'd4;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("fullpop drain%0d", i), key_code, exp_q[i]);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
      end
    end
    check("fullpop drained", key_valid, 0);

    // Reset during HOLD with two codes queued
    press_key(0, 1, 1'b1, "rh_a");
    press_key(3, 2, 1'b0, "rh_b");
    check("rh count", fifo_count, 2);
    check("rh holding", key_pressed, 4'b0100);
    n_reset = 1'b0;
    #1;
    check("rh columnas", columnas, 4'b1110);
    check("rh count cleared", fifo_count, 0);
    check("rh valid cleared", key_valid, 0);
    check("rh pressed cleared", key_pressed, 0);
    check("rh overflow", overflow, 0);
    keys = '0;
    repeat (2) tick();
    n_reset = 1'b1;
    repeat (30) tick();
    check("rh post valid", key_valid, 0);
    check("rh post count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
